jogo_memoria_param: RTL and testbench

//  Parametrised successor of the memory-game core: N_BTN buttons/LEDs, up to MAX_ROUNDS rounds,

---
 rtl/jogo_memoria_pkg.sv | 56 +++++
 rtl/jogo_memoria_param_gerador_sequencia.sv | 32 +++
 rtl/jogo_memoria_param.sv | 224 ++++++++++++++++++++++
 tb/tb_jogo_memoria_param.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the memory-game core: state codes, mode bit indices,
// and the LFSR constants used when the SEQ_LFSR_EN sequence source is built in.
package jogo_memoria_pkg;

  // State codes as seen on db_estado (5-bit, decoded by the 7-seg debug path)
  localparam logic [4:0] EST_INICIAL     = 5'd0;
  localparam logic [4:0] EST_PREPARA     = 5'd1;
  localparam logic [4:0] EST_MOSTRA      = 5'd2;
  localparam logic [4:0] EST_APAGA       = 5'd3;
  localparam logic [4:0] EST_PROX_LED    = 5'd4;
  localparam logic [4:0] EST_ESPERA      = 5'd5;
  localparam logic [4:0] EST_REGISTRA    = 5'd6;
  localparam logic [4:0] EST_COMPARA     = 5'd7;
  localparam logic [4:0] EST_PROX_JOGADA = 5'd8;
  localparam logic [4:0] EST_PROX_RODADA = 5'd9;
  localparam logic [4:0] EST_GANHOU      = 5'd10;
  localparam logic [4:0] EST_PERDEU      = 5'd11;
  localparam logic [4:0] EST_TIMEOUT     = 5'd12;

  typedef enum logic [4:0] {
    S_INICIAL     = EST_INICIAL,
    S_PREPARA     = EST_PREPARA,
    S_MOSTRA      = EST_MOSTRA,
    S_APAGA       = EST_APAGA,
    S_PROX_LED    = EST_PROX_LED,
    S_ESPERA      = EST_ESPERA,
    S_REGISTRA    = EST_REGISTRA,
    S_COMPARA     = EST_COMPARA,
    S_PROX_JOGADA = EST_PROX_JOGADA,
    S_PROX_RODADA = EST_PROX_RODADA,
    S_GANHOU      = EST_GANHOU,
    S_PERDEU      = EST_PERDEU,
    S_TIMEOUT     = EST_TIMEOUT
  } estado_t;

  // Bit positions inside configuracao
  localparam int MODO_CURTO   = 0;
  localparam int MODO_TIMEOUT = 1;

  // Fibonacci LFSR x^16+x^14+x^13+x^11+1, shifting right: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return {^(v & LFSR_TAPS), v[15:1]};
  endfunction

  // Mixes the game seed with a sequence position; stable for a given (seed, k)
  function automatic logic [15:0] seq_hash(input logic [15:0] seed, input logic [15:0] k);
    logic [15:0] h;
    h = seed ^ (k * 16'h9E37);
    h = h ^ {h[7:0], h[15:8]};
    return h ^ (h >> 7);
  endfunction

endpackage

// File: rtl/jogo_memoria_param_gerador_sequencia.sv
// Sequence source: maps a sequence position to the one-hot LED/button it stands for.
// Without SEQ_LFSR_EN the pattern is a fixed rotation; with it, the position is
// hashed with the per-game seed so every game differs but replays stay identical.
module gerador_sequencia
  import jogo_memoria_pkg::*;
#(
  parameter int N_BTN = 4,
  parameter int AW    = 4
) (
`ifdef SEQ_LFSR_EN
  input  logic [15:0]      semente_i,
`endif
  input  logic [AW-1:0]    endereco_i,
  output logic [N_BTN-1:0] seq_o
);

  int unsigned idx;

`ifdef SEQ_LFSR_EN
  assign idx = 32'(seq_hash(semente_i, 16'(endereco_i))) % 32'(N_BTN);
`else
  assign idx = 32'(endereco_i) % 32'(N_BTN);
`endif

  // One decoder bit per button keeps the output strictly one-hot
  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_onehot
      assign seq_o[gi] = (idx == 32'(gi));
    end
  endgenerate

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-game core: replays a growing one-hot sequence on leds and checks the
// player's presses round by round, ending in GANHOU, PERDEU or TIMEOUT.
// Optional macro SEQ_LFSR_EN switches the sequence to an LFSR-seeded pattern.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int MAX_ROUNDS  = 16,
  parameter int LED_ON_CYC  = 500,
  parameter int LED_OFF_CYC = 250,
  parameter int TIMEOUT_CYC = 5000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          jogar,
  input  logic [1:0]                    configuracao,
  input  logic [N_BTN-1:0]              botoes,
  output logic [N_BTN-1:0]              leds,
  output logic                          pronto,
  output logic                          ganhou,
  output logic                          perdeu,
  output logic                          timeout,
  output logic [4:0]                    db_estado,
  output logic [$clog2(MAX_ROUNDS)-1:0] db_rodada
);

  localparam int RW    = $clog2(MAX_ROUNDS);
  localparam int T_MAX = (TIMEOUT_CYC > LED_ON_CYC)
                         ? ((TIMEOUT_CYC > LED_OFF_CYC) ? TIMEOUT_CYC : LED_OFF_CYC)
                         : ((LED_ON_CYC > LED_OFF_CYC) ? LED_ON_CYC : LED_OFF_CYC);
  localparam int TW    = $clog2(T_MAX + 1);

  localparam logic [TW-1:0] T_ON_FIM  = TW'(LED_ON_CYC - 1);
  localparam logic [TW-1:0] T_OFF_FIM = TW'(LED_OFF_CYC - 1);
  localparam logic [TW-1:0] T_TO_FIM  = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] ULT_LONGA = RW'(MAX_ROUNDS - 1);
  localparam logic [RW-1:0] ULT_CURTA = RW'(MAX_ROUNDS / 2 - 1);

  estado_t          estado_q;
  logic [RW-1:0]    rodada_q;
  logic [RW-1:0]    endereco_q;
  logic [RW-1:0]    ultima_q;        // last round index of this game (limite-1)
  logic [TW-1:0]    timer_q;
  logic             modo_timeout_q;
  logic [N_BTN-1:0] botoes_ant_q;
  logic [N_BTN-1:0] jogada_q;
  logic [N_BTN-1:0] leds_q;
  logic             pronto_q;
  logic             ganhou_q;
  logic             perdeu_q;
  logic             timeout_q;

  logic [N_BTN-1:0] seq_w;
  logic             press_w;
  logic             timer_sat_w;

  // A press is the rising edge of "any button down"; a held button never re-triggers
  assign press_w     = (|botoes) && !(|botoes_ant_q);
  // Without a timeout the timer parks at all-ones instead of wrapping
  assign timer_sat_w = &timer_q;

`ifdef SEQ_LFSR_EN
  logic [15:0] lfsr_q;
  logic [15:0] semente_q;

  // Free-running LFSR; its value when a game starts becomes that game's seed
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q    <= LFSR_SEED;
      semente_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_step(lfsr_q);
      if (estado_q == S_PREPARA) semente_q <= lfsr_q;
    end
  end

  gerador_sequencia #(.N_BTN(N_BTN), .AW(RW)) u_seq (
    .semente_i  (semente_q),
    .endereco_i (endereco_q),
    .seq_o      (seq_w)
  );
`else
  gerador_sequencia #(.N_BTN(N_BTN), .AW(RW)) u_seq (
    .endereco_i (endereco_q),
    .seq_o      (seq_w)
  );
`endif

  // Game FSM with its counters and registered outputs
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado_q       <= S_INICIAL;
      rodada_q       <= '0;
      endereco_q     <= '0;
      ultima_q       <= '0;
      timer_q        <= '0;
      modo_timeout_q <= 1'b0;
      botoes_ant_q   <= '0;
      jogada_q       <= '0;
      leds_q         <= '0;
      pronto_q       <= 1'b0;
      ganhou_q       <= 1'b0;
      perdeu_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      botoes_ant_q <= botoes;
      case (estado_q)
        S_INICIAL, S_GANHOU, S_PERDEU, S_TIMEOUT: begin
          if (jogar) begin
            estado_q  <= S_PREPARA;
            leds_q    <= '0;
            pronto_q  <= 1'b0;
            ganhou_q  <= 1'b0;
            perdeu_q  <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_PREPARA: begin
          // Mode is captured here only and held for the whole game
          modo_timeout_q <= configuracao[MODO_TIMEOUT];
          ultima_q       <= configuracao[MODO_CURTO] ? ULT_CURTA : ULT_LONGA;
          rodada_q       <= '0;
          endereco_q     <= '0;
          timer_q        <= '0;
          estado_q       <= S_MOSTRA;
        end
        S_MOSTRA: begin
          leds_q <= seq_w;
          if (timer_q == T_ON_FIM) begin
            leds_q   <= '0;
            timer_q  <= '0;
            estado_q <= S_APAGA;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_APAGA: begin
          if (timer_q == T_OFF_FIM) begin
            timer_q  <= '0;
            estado_q <= S_PROX_LED;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_PROX_LED: begin
          timer_q <= '0;
          if (endereco_q == rodada_q) begin
            endereco_q <= '0;
            estado_q   <= S_ESPERA;
          end else begin
            endereco_q <= endereco_q + RW'(1);
            estado_q   <= S_MOSTRA;
          end
        end
        S_ESPERA: begin
          leds_q <= botoes;
          if (press_w) begin
            jogada_q <= botoes;
            estado_q <= S_REGISTRA;
          end else if (modo_timeout_q && (timer_q == T_TO_FIM)) begin
            leds_q    <= '0;
            pronto_q  <= 1'b1;
            perdeu_q  <= 1'b1;
            timeout_q <= 1'b1;
            estado_q  <= S_TIMEOUT;
          end else if (!timer_sat_w) begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_REGISTRA: begin
          leds_q   <= botoes;
          estado_q <= S_COMPARA;
        end
        S_COMPARA: begin
          // seq_w is one-hot, so a multi-button press can never match
          leds_q <= botoes;
          if (jogada_q == seq_w) begin
            estado_q <= S_PROX_JOGADA;
          end else begin
            leds_q   <= '0;
            pronto_q <= 1'b1;
            perdeu_q <= 1'b1;
            estado_q <= S_PERDEU;
          end
        end
        S_PROX_JOGADA: begin
          leds_q <= botoes;
          if (endereco_q == rodada_q) begin
            estado_q <= S_PROX_RODADA;
          end else if (botoes == '0) begin
            endereco_q <= endereco_q + RW'(1);
            timer_q    <= '0;
            estado_q   <= S_ESPERA;
          end
        end
        S_PROX_RODADA: begin
          leds_q <= '0;
          if (rodada_q == ultima_q) begin
            pronto_q <= 1'b1;
            ganhou_q <= 1'b1;
            estado_q <= S_GANHOU;
          end else begin
            rodada_q   <= rodada_q + RW'(1);
            endereco_q <= '0;
            timer_q    <= '0;
            estado_q   <= S_MOSTRA;
          end
        end
        default: begin
          estado_q <= S_INICIAL;
        end
      endcase
    end
  end

  assign leds      = leds_q;
  assign pronto    = pronto_q;
  assign ganhou    = ganhou_q;
  assign perdeu    = perdeu_q;
  assign timeout   = timeout_q;
  assign db_estado = estado_q;
  assign db_rodada = rodada_q;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param (N_BTN=4, MAX_ROUNDS=4, LED_ON=4,
// LED_OFF=2, TIMEOUT=50, fixed sequence 0001,0010,0100,1000).
module tb_jogo_memoria_param;
  import jogo_memoria_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       jogar = 1'b0;
  logic [1:0] configuracao = 2'b00;
  logic [3:0] botoes = 4'b0000;
  logic [3:0] leds;
  logic       pronto, ganhou, perdeu, timeout;
  logic [4:0] db_estado;
  logic [1:0] db_rodada;

  int n_assert = 0;
  int n_fail   = 0;

  jogo_memoria_param #(
    .N_BTN(4), .MAX_ROUNDS(4), .LED_ON_CYC(4), .LED_OFF_CYC(2), .TIMEOUT_CYC(50)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .jogar        (jogar),
    .configuracao (configuracao),
    .botoes       (botoes),
    .leds         (leds),
    .pronto       (pronto),
    .ganhou       (ganhou),
    .perdeu       (perdeu),
    .timeout      (timeout),
    .db_estado    (db_estado),
    .db_rodada    (db_rodada)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Bounded wait for a state; an expired budget shows up as a failed check
  task automatic wait_state(input logic [4:0] st, input int budget, input string tag);
    int n = 0;
    while (db_estado !== st && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(tag, 32'(db_estado), 32'(st));
  endtask

  // Called at a negedge in ESPERA; returns two cycles later (state COMPARA)
  task automatic press(input logic [3:0] b);
    $display("press %b rodada=%0d estado=%0d", b, db_rodada, db_estado);
    botoes = b;
    tick(2);
    botoes = 4'b0000;
  endtask

  task automatic start(input logic [1:0] cfg);
    configuracao = cfg;
    jogar = 1'b1;
    tick(1);
    jogar = 1'b0;
    $display("start cfg=%b estado=%0d", cfg, db_estado);
  endtask

  task automatic play_round(input int r);
    for (int k = 0; k <= r; k++) begin
      wait_state(EST_ESPERA, 200, "espera");
      press(4'b0001 << (k % 4));
    end
  endtask

  initial begin
    // Power-up reset
    tick(1);
    check("rst_estado", 32'(db_estado), 32'(EST_INICIAL));
    check("rst_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b0000));
    check("rst_leds", 32'(leds), 32'(4'b0000));
    reset = 1'b1;
    tick(1);

    // 1: reset in the middle of MOSTRA aborts at once
    start(2'b00);
    check("prepara", 32'(db_estado), 32'(EST_PREPARA));
    tick(2);
    check("mostra_estado", 32'(db_estado), 32'(EST_MOSTRA));
    check("mostra_led0", 32'(leds), 32'(4'b0001));
    reset = 1'b0;
    #1;
    check("abort_estado", 32'(db_estado), 32'(EST_INICIAL));
    check("abort_leds", 32'(leds), 32'(4'b0000));
    check("abort_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b0000));
    tick(1);
    reset = 1'b1;
    tick(1);

    // 2: full 4-round game, all correct
    start(2'b00);
    for (int r = 0; r < 4; r++) play_round(r);
    wait_state(EST_GANHOU, 100, "ganhou_estado");
    check("ganhou_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b1100));
    check("ganhou_rodada", 32'(db_rodada), 32'(2'd3));

    // 3: wrong second press in round 1; verdict two cycles after the press
    start(2'b00);
    play_round(0);
    wait_state(EST_ESPERA, 200, "espera_r1");
    press(4'b0001);
    wait_state(EST_ESPERA, 20, "espera_r1b");
    press(4'b0100);
    check("latencia_compara", 32'(db_estado), 32'(EST_COMPARA));
    tick(1);
    check("perdeu_estado", 32'(db_estado), 32'(EST_PERDEU));
    check("perdeu_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b1010));
    check("perdeu_rodada", 32'(db_rodada), 32'(2'd1));

    // 4: timeout after exactly 50 idle ESPERA cycles
    start(2'b10);
    wait_state(EST_ESPERA, 200, "espera_to");
    tick(49);
    check("to_ultimo_ciclo", 32'(db_estado), 32'(EST_ESPERA));
    tick(1);
    check("to_estado", 32'(db_estado), 32'(EST_TIMEOUT));
    check("to_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b1011));

    // 4b: no timeout mode, long idle; config changes and jogar mid-game ignored
    start(2'b00);
    check("reinicio_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b0000));
    wait_state(EST_ESPERA, 200, "espera_idle");
    tick(200);
    check("idle_estado", 32'(db_estado), 32'(EST_ESPERA));
    configuracao = 2'b10;
    tick(60);
    check("cfg_retida", 32'(db_estado), 32'(EST_ESPERA));
    jogar = 1'b1;
    tick(2);
    jogar = 1'b0;
    check("jogar_ignorado", 32'(db_estado), 32'(EST_ESPERA));

    // 5b: two buttons at once never match
    press(4'b0011);
    tick(1);
    check("multi_estado", 32'(db_estado), 32'(EST_PERDEU));
    check("multi_rodada", 32'(db_rodada), 32'(2'd0));

    // 5: short game ends after round 1
    start(2'b01);
    play_round(0);
    play_round(1);
    wait_state(EST_GANHOU, 100, "curto_estado");
    check("curto_flags", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b1100));
    check("curto_rodada", 32'(db_rodada), 32'(2'd1));

    // 6: restart from GANHOU, held button not counted, jogar in MOSTRA ignored
    start(2'b00);
    check("ganhou_prepara", 32'(db_estado), 32'(EST_PREPARA));
    check("ganhou_limpo", 32'({pronto, ganhou, perdeu, timeout}), 32'(4'b0000));
    wait_state(EST_APAGA, 100, "apaga");
    botoes = 4'b0001;
    wait_state(EST_ESPERA, 100, "espera_segurado");
    tick(5);
    check("segurado_ignorado", 32'(db_estado), 32'(EST_ESPERA));
    check("eco_leds", 32'(leds), 32'(4'b0001));
    botoes = 4'b0000;
    tick(2);
    press(4'b0001);
    wait_state(EST_MOSTRA, 20, "mostra_r1");
    jogar = 1'b1;
    tick(2);
    jogar = 1'b0;
    check("jogar_mostra", 32'(db_estado), 32'(EST_MOSTRA));
    check("mostra_r1_rodada", 32'(db_rodada), 32'(2'd1));
    check("mostra_r1_led0", 32'(leds), 32'(4'b0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
